// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity framer.
package parity_pkg;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_framer_if.sv
// Serial stream handshake between an upstream bit source and the framer.
interface serial_parity_framer_if;

  logic i_valid;
  logic i_x;
  logic i_odd;
  logic o_ready;
  logic o_y;
  logic o_y_valid;
  logic o_par_flag;

  // Upstream side: presents bits, observes the framed output stream.
  modport master (
    output i_valid, i_x, i_odd,
    input  o_ready, o_y, o_y_valid, o_par_flag
  );

  modport slave (
    input  i_valid, i_x, i_odd,
    output o_ready, o_y, o_y_valid, o_par_flag
  );

endinterface

// File: rtl/frame_bit_counter.sv
// Modulo-DATA_BITS bit counter with enable, synchronous clear and terminal count.
module frame_bit_counter #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = $clog2(DATA_BITS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

  assign o_tc = (o_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_tc ? '0 : o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// Frames a serial bit stream into DATA_BITS data bits followed by one parity bit.
module serial_parity_framer
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = $clog2(DATA_BITS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  serial_parity_framer_if.slave  bus,
  output logic                   o_p,
  output logic [CNT_W-1:0]       o_bit_cnt,
  output logic [7:0]             o_frames
);

  state_t     state_q, state_d;
  logic       y_q, y_d;
  logic       y_valid_q, y_valid_d;
  logic       par_flag_q, par_flag_d;
  logic       parity_q, parity_d;
  logic       mode_q, mode_d;
  logic [7:0] frames_q, frames_d;
  logic       ready;
  logic       accept;
  logic       last_bit;

  assign ready  = (state_q == S_DATA);
  assign accept = bus.i_valid && ready && !i_clr;

  frame_bit_counter #(
    .DATA_BITS (DATA_BITS),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_en    (accept),
    .o_cnt   (o_bit_cnt),
    .o_tc    (last_bit)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;
    par_flag_d = 1'b0;
    parity_d   = parity_q;
    mode_d     = mode_q;
    frames_d   = frames_q;

    if (i_clr) begin
      // Abort drops the bit on the wire and any pending parity emission.
      state_d  = S_DATA;
      parity_d = 1'b0;
      mode_d   = PAR_EVEN;
    end else begin
      unique case (state_q)
        S_DATA: begin
          if (accept) begin
            y_d       = bus.i_x;
            y_valid_d = 1'b1;
            parity_d  = parity_q ^ bus.i_x;
            if (o_bit_cnt == '0) begin
              mode_d = bus.i_odd ? PAR_ODD : PAR_EVEN;
            end
            if (last_bit) begin
              state_d = S_PARITY;
            end
          end
        end
        S_PARITY: begin
          y_d        = parity_q ^ mode_q;
          y_valid_d  = 1'b1;
          par_flag_d = 1'b1;
          parity_d   = 1'b0;
          frames_d   = frames_q + 8'd1;
          state_d    = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_DATA;
      y_q        <= 1'b0;
      y_valid_q  <= 1'b0;
      par_flag_q <= 1'b0;
      parity_q   <= 1'b0;
      mode_q     <= PAR_EVEN;
      frames_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      par_flag_q <= par_flag_d;
      parity_q   <= parity_d;
      mode_q     <= mode_d;
      frames_q   <= frames_d;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_y        = y_q;
  assign bus.o_y_valid  = y_valid_q;
  assign bus.o_par_flag = par_flag_q;
  assign o_p            = parity_q ^ mode_q;
  assign o_frames       = frames_q;

endmodule
